// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit (package if_pkg).
package if_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    ERROR  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } fetch_entry_t;

  localparam logic [15:0] INST_BYTES = 16'd2;

  // Sequential fetch address; wraps modulo 2^16.
  function automatic logic [15:0] next_pc(input logic [15:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Fetch buffer: small FIFO of fetch_entry_t with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  // Pointer and occupancy next-state; flush overrides push and pop.
  always_comb begin
    pop_ok_s  = pop_i & (count_q != {CW{1'b0}});
    push_ok_s = push_i & ((count_q < FULL) | pop_ok_s);
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    if (flush_i) begin
      rd_d    = {AW{1'b0}};
      wr_d    = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_d = wr_q + PTR_ONE;
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok_s) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= {AW{1'b0}};
      wr_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {32{1'b0}};
      end
    end else if (push_ok_s && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: sequential 16-bit fetch into a small buffer with redirect/halt/error.
// Define IF_FETCH_BYPASS_EN to forward a fetched word straight to the consumer when the buffer is empty.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] inst_out,
  output logic [15:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err
);

  localparam int            CW   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [CW-1:0] count_s;
  fetch_entry_t  head_s, push_data_s;
  logic          head_valid_s, buf_pop_s, fetch_s, fetch_ok_s, push_s, bypass_s;

  // State and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state; redirect beats everything, an odd target is an immediate error.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = redirect_pc[0] ? ERROR : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (fetch_s && mem_err) begin
            state_d = ERROR;
          end else if (halt) begin
            state_d = HALTED;
          end else begin
            state_d = RUN;
          end
        end
        HALTED: begin
          if (!halt) begin
            state_d = RUN;
          end else begin
            state_d = HALTED;
          end
        end
        ERROR:   state_d = ERROR;
        default: state_d = ERROR;
      endcase
    end
  end

  // Fetch handshake and consumer-facing outputs.
  always_comb begin
    head_valid_s = (count_s != {CW{1'b0}});
    // Only a buffered head can free a slot, which keeps mem_enable off the bypass path.
    buf_pop_s    = head_valid_s & inst_ready;
    fetch_s      = rst & (state_q == RUN) & ~halt & ~redirect & ((count_s < FULL) | buf_pop_s);
    fetch_ok_s   = fetch_s & ~mem_err;
`ifdef IF_FETCH_BYPASS_EN
    bypass_s     = fetch_ok_s & ~head_valid_s;
`else
    bypass_s     = 1'b0;
`endif
    push_s       = fetch_ok_s & ~(bypass_s & inst_ready);
    inst_valid   = head_valid_s | bypass_s;
    if (bypass_s) begin
      inst_out = mem_rdata;
      pc_out   = pc_q;
    end else begin
      inst_out = head_s.inst;
      pc_out   = head_s.pc;
    end
    mem_enable   = fetch_s;
    fetch_err    = (state_q == ERROR) & ~head_valid_s;
  end

  // Next PC: faulting fetches hold the PC.
  always_comb begin
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (fetch_ok_s) begin
      pc_d = next_pc(pc_q);
    end else begin
      pc_d = pc_q;
    end
  end

  assign push_data_s = {pc_q, mem_rdata};
  assign mem_addr    = pc_q;
  assign mem_wr      = 1'b0;
  assign mem_wdata   = 16'h0000;

  if_fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (redirect),
    .push_i  (push_s),
    .pop_i   (buf_pop_s),
    .data_i  (push_data_s),
    .head_o  (head_s),
    .count_o (count_s)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a reference model predicts fetches and queues expected entries.
module tb_if_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_err;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;
  logic        err_inj;

  int          n_vec;
  int          n_err;
  logic [15:0] m_pc;
  int          m_st;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign mem_rdata = mem_fn(mem_addr);
  assign mem_err   = err_inj;

  if_fetch #(
    .RESET_PC  (16'h0010),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_enable  (mem_enable),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .fetch_err   (fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc = 16'h0010;
    m_st = 0;
  endtask

  // Compare this cycle's outputs against the model, then advance the model over the coming edge.
  task automatic eval_cycle();
    logic        pop;
    logic        en;
    logic        byp;
    logic [31:0] head;
    if (!rst) begin
      check("rst_mem_enable", 32'(mem_enable), 32'(1'b0));
      check("rst_inst_valid", 32'(inst_valid), 32'(1'b0));
      check("rst_fetch_err", 32'(fetch_err), 32'(1'b0));
      model_reset();
      return;
    end
    pop = (sb.size() != 0) && inst_ready;
    en  = (m_st == 0) && !halt && !redirect && ((sb.size() < DEPTH) || pop);
    byp = 1'b0;
`ifdef IF_FETCH_BYPASS_EN
    byp = en && !err_inj && (sb.size() == 0);
`endif
    check("mem_enable", 32'(mem_enable), 32'(en));
    if (en) check("mem_addr", 32'(mem_addr), 32'(m_pc));
    check("inst_valid", 32'(inst_valid), 32'((sb.size() != 0) || byp));
    check("fetch_err", 32'(fetch_err), 32'((m_st == 2) && (sb.size() == 0)));
    if (pop) begin
      head = sb.pop_front();
      check("pc_out", 32'(pc_out), 32'(head[31:16]));
      check("inst_out", 32'(inst_out), 32'(head[15:0]));
    end else if (byp && inst_ready) begin
      check("byp_pc_out", 32'(pc_out), 32'(m_pc));
      check("byp_inst_out", 32'(inst_out), 32'(mem_fn(m_pc)));
    end
    if (redirect) begin
      sb.delete();
      m_pc = redirect_pc;
      m_st = redirect_pc[0] ? 2 : 0;
    end else begin
      if (en && !err_inj) begin
        if (!(byp && inst_ready)) sb.push_back({m_pc, mem_fn(m_pc)});
        m_pc = m_pc + 16'd2;
      end
      case (m_st)
        0: begin
          if (en && err_inj) m_st = 2;
          else if (halt) m_st = 1;
        end
        1: if (!halt) m_st = 0;
        default: m_st = m_st;
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    inst_ready  = 1'b0;
    err_inj     = 1'b0;
    model_reset();
    #1;
    cycle();
    cycle();
    check("mem_wr", 32'(mem_wr), 32'(1'b0));
    check("mem_wdata", 32'(mem_wdata), 32'(16'h0000));

    // Sequential fetch from RESET_PC.
    rst = 1'b1; inst_ready = 1'b1;
    repeat (6) cycle();

    // Backpressure fills the buffer, then release.
    inst_ready = 1'b0;
    repeat (5) cycle();
    inst_ready = 1'b1;
    repeat (6) cycle();

    // Redirect while full.
    inst_ready = 1'b0;
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 16'h0100;
    cycle();
    redirect = 1'b0; inst_ready = 1'b1;
    repeat (5) cycle();

    // Halt and resume.
    halt = 1'b1;
    repeat (3) cycle();
    halt = 1'b0;
    repeat (4) cycle();

    // Memory error with entries still buffered, then drain.
    inst_ready = 1'b0; err_inj = 1'b1;
    cycle();
    err_inj = 1'b0;
    repeat (3) cycle();
    inst_ready = 1'b1;
    repeat (4) cycle();

    // Odd redirect target, then recovery.
    redirect = 1'b1; redirect_pc = 16'h0101;
    cycle();
    redirect = 1'b0;
    repeat (3) cycle();
    redirect = 1'b1; redirect_pc = 16'h0200;
    cycle();
    redirect = 1'b0;
    repeat (4) cycle();

    // PC wrap.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    cycle();
    redirect = 1'b0;
    repeat (4) cycle();

    // Asynchronous reset mid-stream, checked before the next edge.
    #2;
    rst = 1'b0;
    #1;
    check("arst_inst_valid", 32'(inst_valid), 32'(1'b0));
    check("arst_mem_enable", 32'(mem_enable), 32'(1'b0));
    check("arst_fetch_err", 32'(fetch_err), 32'(1'b0));
    model_reset();
    cycle();
    rst = 1'b1;
    repeat (4) cycle();

    // Random mix of backpressure, halt and even redirects.
    repeat (40) begin
      inst_ready  = 1'($urandom_range(0, 1));
      halt        = ($urandom_range(0, 7) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      cycle();
    end
    halt = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, which is the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, which is the number of fetch buffer entries (legal values 2 and 4).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: asynchronous assert, active-low.
REQ-005 SHALL have port mem_addr, output, 16 bits, the byte address to instruction memory.
REQ-006 SHALL have port mem_enable, output, 1 bit, the memory access request.
REQ-007 SHALL have port mem_wr, output, 1 bit, the write strobe, tied 0.
REQ-008 SHALL have port mem_wdata, output, 16 bits, the write data, tied 16'h0.
REQ-009 SHALL have port mem_rdata, input, 16 bits, the big-endian instruction word, valid in the same cycle as the request.
REQ-010 SHALL have port mem_err, input, 1 bit, the memory error flag (unaligned access) for the current request.
REQ-011 SHALL have port redirect, input, 1 bit, the branch/jump redirect request.
REQ-012 SHALL have port redirect_pc, input, 16 bits, the redirect target.
REQ-013 SHALL have port halt, input, 1 bit, the request to stop issuing fetches while high.
REQ-014 SHALL have port inst_out, output, 16 bits, the instruction at the buffer head.
REQ-015 SHALL have port pc_out, output, 16 bits, the PC of inst_out.
REQ-016 SHALL have port inst_valid, output, 1 bit, the head entry valid flag.
REQ-017 SHALL have port inst_ready, input, 1 bit, the consumer accepting the head entry.
REQ-018 SHALL have port fetch_err, output, 1 bit, the sticky fetch error indicator.

Function
REQ-019 SHALL implement states RUN, HALTED and ERROR.
REQ-020 SHALL make RUN -> HALTED on halt=1; HALTED -> RUN on halt=0; RUN -> ERROR on mem_enable & mem_err; any state -> RUN on redirect with redirect_pc[0]=0; any state -> ERROR on redirect with redirect_pc[0]=1.
REQ-021 SHALL assert mem_enable = (state==RUN) & ~halt & ~redirect & (count<BUF_DEPTH | pop), where pop = inst_valid & inst_ready, and SHALL drive mem_addr = pc.
REQ-022 SHALL, on a fetch without mem_err, push {pc, mem_rdata} into the buffer and update pc <= pc + 2, with modulo-2^16 wrap (16'hFFFE -> 16'h0000).
REQ-023 SHALL, on a fetch with mem_err, push nothing, hold pc, and enter ERROR.
REQ-024 SHALL allow pop and push in the same cycle when the buffer is full, leaving count unchanged.
REQ-025 SHALL present data as FIFO head: inst_valid = (count != 0); inst_out/pc_out are don't-care when inst_valid=0.
REQ-026 SHALL flush all entries on redirect, set pc <= redirect_pc, and issue no fetch that cycle; redirect has priority over halt, pop and fetch.
REQ-027 SHALL, in ERROR, issue no fetches and drain the buffer normally; fetch_err=1 once state==ERROR and count==0.
REQ-028 SHALL deliver the first inst_valid one cycle after the fetch cycle (registered buffer).

Reset
REQ-029 SHALL, while rst=0, immediately set: state=RUN, pc=RESET_PC, count=0, inst_valid=0, fetch_err=0, mem_enable=0.
REQ-030 SHALL make the first fetch occur in the first cycle after rst deasserts, at RESET_PC.

Configuration
REQ-031 SHALL, with macro IF_FETCH_BYPASS_EN defined and count==0, forward the fetched word combinationally: inst_valid=1, inst_out=mem_rdata, pc_out=pc in the fetch cycle; if inst_ready=1 the word is not pushed.
REQ-032 SHALL, with IF_FETCH_BYPASS_EN undefined, use the one-cycle registered latency per REQ-028 only.

Structure
REQ-033 SHALL take fetch_state_e (RUN/HALTED/ERROR), fetch_entry_t {pc[15:0], inst[15:0]} and the constant INST_BYTES=2 from shared package if_pkg.
REQ-034 SHALL implement the buffer as sub-module if_fetch_buf: a parameterized FIFO of fetch_entry_t with push, pop, flush and count.

Verification
REQ-035 SHALL check that reset with RESET_PC=16'h0010 and inst_ready=1 gives mem_addr 0010, 0012, 0014 on consecutive cycles, with inst_valid from the cycle after the first fetch and pc_out matching.
REQ-036 SHALL check that inst_ready=0 for 5 cycles causes mem_enable to drop after 2 fetches (BUF_DEPTH=2), and inst_ready=1 then resumes with one fetch per cycle and no lost or duplicated PC.
REQ-037 SHALL check that redirect=1 with redirect_pc=16'h0100 while the buffer is full gives inst_valid=0 next cycle, then mem_addr=0100, with no stale entries delivered.
REQ-038 SHALL check that redirect_pc=16'h0101 causes no fetch and fetch_err=1 once drained, and a later redirect to 16'h0200 clears fetch_err and fetches 0200.
REQ-039 SHALL check that pc=16'hFFFE fetches at FFFE then 0000, and rst=0 asserted mid-stream clears inst_valid asynchronously before the next clock edge.
REQ-040 SHALL check that, with IF_FETCH_BYPASS_EN defined, an empty buffer and inst_ready=1 gives inst_valid in the fetch cycle itself with inst_out=mem_rdata.
